// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus between pc_fetch_ctrl (master) and the instruction memory (slave).
// Request/address come from the fetch controller; ack/rdata return from memory.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer and instruction-fetch handshake with flush > branch > jump redirects.
// Optional macro PC_MISALIGN_TRAP_EN traps misaligned branch/jump targets (misalign_o/misalign_addr_o).
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jmp_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  pc_fetch_ctrl_if.master   imem,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, TRAP} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inst_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;

  logic [ADDR_W-1:0] w_pc_next;
  logic              w_pend_valid_next;
  logic [ADDR_W-1:0] w_pend_pc_next;
  logic              w_req_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_inst_valid_next;
  logic [31:0]       w_inst_next;
  logic [ADDR_W-1:0] w_inst_pc_next;

  logic              w_redir;
  logic [ADDR_W-1:0] w_raw_target;
  logic [ADDR_W-1:0] w_target;
  logic              w_misalign;
  logic              w_trap;

`ifdef PC_MISALIGN_TRAP_EN
  logic              r_mis;
  logic [ADDR_W-1:0] r_mis_addr;
`endif

  // Only the highest-priority redirect's target is used; low two bits are never fetched.
  always_comb begin
    w_redir      = flush_i | br_taken_i | jmp_i;
    w_raw_target = jmp_target_i;
    if (flush_i)
      w_raw_target = flush_pc_i;
    else if (br_taken_i)
      w_raw_target = br_target_i;
    w_target   = w_raw_target & ~ADDR_W'(3);
    w_misalign = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    w_misalign = !flush_i && (w_raw_target[1:0] != 2'b00);
`endif
    w_trap = w_redir & w_misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_trap ? TRAP : REQ;
      REQ: begin
        if (w_trap)
          w_state_next = TRAP;
        else if (imem.imem_ack && !w_redir && !r_pend_valid)
          w_state_next = RESP;
      end
      RESP: begin
        if (w_trap)
          w_state_next = TRAP;
        else if (w_redir || !stall_i)
          w_state_next = REQ;
      end
      TRAP:    if (flush_i) w_state_next = REQ;
      default: w_state_next = IDLE;
    endcase
  end

  // A response whose request was overtaken by a redirect is dropped and the redirect is fetched instead.
  always_comb begin
    w_pc_next         = r_pc;
    w_pend_valid_next = r_pend_valid;
    w_pend_pc_next    = r_pend_pc;
    w_req_next        = 1'b0;
    w_addr_next       = r_addr;
    w_inst_valid_next = 1'b0;
    w_inst_next       = r_inst;
    w_inst_pc_next    = r_inst_pc;
    case (r_state)
      IDLE: begin
        if (!w_trap) begin
          w_pc_next   = w_redir ? w_target : r_pc;
          w_req_next  = 1'b1;
          w_addr_next = w_redir ? w_target : r_pc;
        end
      end
      REQ: begin
        if (w_trap) begin
          w_pend_valid_next = 1'b0;
        end else if (imem.imem_ack) begin
          w_pend_valid_next = 1'b0;
          if (w_redir) begin
            w_pc_next   = w_target;
            w_req_next  = 1'b1;
            w_addr_next = w_target;
          end else if (r_pend_valid) begin
            w_pc_next   = r_pend_pc;
            w_req_next  = 1'b1;
            w_addr_next = r_pend_pc;
          end else begin
            w_pc_next         = r_pc + ADDR_W'(4);
            w_inst_valid_next = 1'b1;
            w_inst_next       = imem.imem_rdata;
            w_inst_pc_next    = r_pc;
          end
        end else begin
          w_req_next = 1'b1;
          if (w_redir) begin
            w_pend_valid_next = 1'b1;
            w_pend_pc_next    = w_target;
          end
        end
      end
      RESP: begin
        if (w_trap) begin
          w_inst_valid_next = 1'b0;
        end else if (w_redir) begin
          w_pc_next   = w_target;
          w_req_next  = 1'b1;
          w_addr_next = w_target;
        end else if (stall_i) begin
          w_inst_valid_next = 1'b1;
        end else begin
          w_req_next  = 1'b1;
          w_addr_next = r_pc;
        end
      end
      TRAP: begin
        if (flush_i) begin
          w_pc_next   = w_target;
          w_req_next  = 1'b1;
          w_addr_next = w_target;
        end
      end
      default: begin
        w_pend_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_pc         <= w_pc_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_pc    <= w_pend_pc_next;
      r_req        <= w_req_next;
      r_addr       <= w_addr_next;
      r_inst_valid <= w_inst_valid_next;
      r_inst       <= w_inst_next;
      r_inst_pc    <= w_inst_pc_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // The trap indication is a single-cycle pulse; the offending address is kept until the next trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= w_trap;
      if (w_trap)
        r_mis_addr <= w_raw_target;
    end
  end

  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_mis_addr;
`endif

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign inst_valid_o   = r_inst_valid;
  assign inst_o         = r_inst;
  assign inst_pc_o      = r_inst_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vectors with literal expectations plus a
// transaction-level model compared every cycle; a second instance covers a wrapping RESET_PC.
module tb_pc_fetch_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, br, jmp;
  logic [AW-1:0] flushPc, brT, jmpT;

  logic          validA, validB;
  logic [31:0]   instA, instB;
  logic [AW-1:0] instPcA, instPcB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.ADDR_W(AW)) ifA ();
  pc_fetch_ctrl_if #(.ADDR_W(AW)) ifB ();

`ifdef PC_MISALIGN_TRAP_EN
  logic          misA, misB;
  logic [AW-1:0] misAddrA, misAddrB;
`endif

  pc_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dutA (
    .clk(clk), .rst(rst), .stall_i(stall),
    .flush_i(flush), .flush_pc_i(flushPc),
    .br_taken_i(br), .br_target_i(brT),
    .jmp_i(jmp), .jmp_target_i(jmpT),
    .imem(ifA.master),
    .inst_valid_o(validA), .inst_o(instA), .inst_pc_o(instPcA)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_o(misA), .misalign_addr_o(misAddrA)
`endif
  );

  pc_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFC)) dutB (
    .clk(clk), .rst(rst), .stall_i(1'b0),
    .flush_i(1'b0), .flush_pc_i(32'h0),
    .br_taken_i(1'b0), .br_target_i(32'h0),
    .jmp_i(1'b0), .jmp_target_i(32'h0),
    .imem(ifB.master),
    .inst_valid_o(validB), .inst_o(instB), .inst_pc_o(instPcB)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_o(misB), .misalign_addr_o(misAddrB)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] fpc,
                               input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic a, input logic [31:0] d);
    stall          = s;
    flush          = f;
    flushPc        = fpc;
    br             = b;
    brT            = bt;
    jmp            = j;
    jmpT           = jt;
    ifA.imem_ack   = a;
    ifA.imem_rdata = d;
    ifB.imem_ack   = a;
    ifB.imem_rdata = d;
    @(negedge clk);
  endtask

  // Reference model: tracks whether a fetch is outstanding or an instruction is held, the next
  // sequential address and any redirect waiting for the outstanding fetch to complete.
  wire           haveRedir = flush | br | jmp;
  wire [AW-1:0]  winPc = (flush ? flushPc : (br ? brT : jmpT)) & ~32'd3;

  logic          mStarted, mPend;
  logic [AW-1:0] mPc, mPendPc;
  logic          expReq, expValid;
  logic [AW-1:0] expAddr, expInstPc;
  logic [31:0]   expInst;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mStarted  <= 1'b0;
      mPend     <= 1'b0;
      mPc       <= 32'h0;
      mPendPc   <= 32'h0;
      expReq    <= 1'b0;
      expAddr   <= 32'h0;
      expValid  <= 1'b0;
      expInst   <= 32'h0;
      expInstPc <= 32'h0;
    end else if (!mStarted) begin
      mStarted <= 1'b1;
      expReq   <= 1'b1;
      expAddr  <= haveRedir ? winPc : mPc;
      mPc      <= haveRedir ? winPc : mPc;
    end else if (expReq) begin
      if (ifA.imem_ack) begin
        mPend <= 1'b0;
        if (haveRedir) begin
          mPc     <= winPc;
          expAddr <= winPc;
        end else if (mPend) begin
          mPc     <= mPendPc;
          expAddr <= mPendPc;
        end else begin
          expReq    <= 1'b0;
          expValid  <= 1'b1;
          expInst   <= ifA.imem_rdata;
          expInstPc <= expAddr;
          mPc       <= expAddr + 32'd4;
        end
      end else if (haveRedir) begin
        mPend   <= 1'b1;
        mPendPc <= winPc;
      end
    end else if (expValid) begin
      if (haveRedir) begin
        expValid <= 1'b0;
        expReq   <= 1'b1;
        expAddr  <= winPc;
        mPc      <= winPc;
      end else if (!stall) begin
        expValid <= 1'b0;
        expReq   <= 1'b1;
        expAddr  <= mPc;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("modelReq", {31'b0, ifA.imem_req}, {31'b0, expReq});
    if (expReq)
      checkOutput("modelAddr", ifA.imem_addr, expAddr);
    checkOutput("modelValid", {31'b0, validA}, {31'b0, expValid});
    if (expValid) begin
      checkOutput("modelInst", instA, expInst);
      checkOutput("modelInstPc", instPcA, expInstPc);
    end
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
    flushPc = '0; brT = '0; jmpT = '0;
    ifA.imem_ack = 1'b0; ifA.imem_rdata = '0;
    ifB.imem_ack = 1'b0; ifB.imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstReq", {31'b0, ifA.imem_req}, 32'h0);
    checkOutput("rstAddr", ifA.imem_addr, 32'h0);
    checkOutput("rstValid", {31'b0, validA}, 32'h0);
    checkOutput("rstInst", instA, 32'h0);
    checkOutput("rstInstPc", instPcA, 32'h0);
    checkOutput("rstAddrB", ifB.imem_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Zero-wait fetches from 0, 4, 8 with a stall on the instruction at 4
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1Addr0", ifA.imem_addr, 32'h0);
    checkOutput("t1Req0", {31'b0, ifA.imem_req}, 32'h1);
    checkOutput("t5AddrB0", ifB.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0011);
    checkOutput("t1Valid0", {31'b0, validA}, 32'h1);
    checkOutput("t1InstPc0", instPcA, 32'h0);
    checkOutput("t5InstPcB", instPcB, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1Addr4", ifA.imem_addr, 32'h4);
    checkOutput("t5AddrB1", ifB.imem_addr, 32'h0);
    checkOutput("t5ReqB1", {31'b0, ifB.imem_req}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t1InstPc4", instPcA, 32'h4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t2HoldValid", {31'b0, validA}, 32'h1);
      checkOutput("t2HoldInst", instA, 32'hDEAD_BEEF);
      checkOutput("t2HoldPc", instPcA, 32'h4);
      checkOutput("t2NoReq", {31'b0, ifA.imem_req}, 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2ReqAddr8", ifA.imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0033);
    checkOutput("t1InstPc8", instPcA, 32'h8);

    // Branch during an unacknowledged fetch: address held, response dropped, then refetch at 0x40
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    checkOutput("t3AddrHeld", ifA.imem_addr, 32'hC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0044);
    checkOutput("t3Dropped", {31'b0, validA}, 32'h0);
    checkOutput("t3Addr40", ifA.imem_addr, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0055);
    checkOutput("t3InstPc40", instPcA, 32'h40);

    // Flush beats branch and overrides stall while an instruction is held
    applyStimulus(1, 1, 32'h100, 1, 32'h40, 0, 0, 0, 0);
    checkOutput("t4Killed", {31'b0, validA}, 32'h0);
    checkOutput("t4Addr100", ifA.imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0066);
    applyStimulus(0, 0, 0, 1, 32'h80, 1, 32'h90, 0, 0);
    checkOutput("brOverJmp", ifA.imem_addr, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h203, 1, 32'h0000_0099);
    checkOutput("jmpAckDrop", {31'b0, validA}, 32'h0);
    checkOutput("jmpAligned", ifA.imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_00AA);
    checkOutput("jmpInst", instA, 32'h0000_00AA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of an outstanding fetch, with a late ack that must be ignored
    #2 rst = 1'b1;
    #1;
    checkOutput("t6RstReq", {31'b0, ifA.imem_req}, 32'h0);
    checkOutput("t6RstAddr", ifA.imem_addr, 32'h0);
    checkOutput("t6RstValid", {31'b0, validA}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0077);
    checkOutput("t6IgnoredAck", {31'b0, validA}, 32'h0);
    checkOutput("t6ResumeAddr", ifA.imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0077);
    checkOutput("t6ResumePc", instPcA, 32'h0);

    // Redirect while idle selects the first fetch address
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h300, 0, 0);
    checkOutput("idleRedirect", ifA.imem_addr, 32'h300);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom % 4) == 0,
                    ($urandom % 10) == 0, $urandom,
                    ($urandom % 8) == 0, {22'b0, 8'($urandom), 2'b00},
                    ($urandom % 8) == 0, {22'b0, 8'($urandom), 2'b00},
                    ($urandom % 2) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
